sar_search: RTL
===============

# sar_search

Successive-approximation search engine that drives a trial value into a magnitude comparator and reads back its greater/equal/less result.
- Resolves an unknown target (held on the comparator's `a` side) by binary search: one comparison per clock, MSB first.
- Sits upstream of the team's comparator blocks (2-bit/4-bit ripple-cascaded).
- Turns their combinational relation outputs back into a registered binary value with a done pulse.

## Interface
- `WIDTH`, default 4: width of trial/result; the comparator instance must be the same width.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new search; sampled only when idle.
- `a_g_b` input 1: comparator result, target > trial.
- `a_e_b` input 1: comparator result, target == trial.
- `a_l_b` input 1: comparator result, target < trial.
- `trial` output WIDTH: value driven to the comparator `b` input.
- `busy` output 1: search in progress.
- `done` output 1: one-cycle pulse, `value` valid.
- `value` output WIDTH: search result, held until the next accepted start.
- `found` output 1: equality was observed during the search.
- `cmp_err` output 1: comparator triple was not one-hot on some sampled step; sticky until the next accepted start.

## Operation
- States:
  - IDLE: `trial`=0, `busy`=0.
  - SEARCH: holds bit index `i` (WIDTH-1 down to 0) and accumulator `acc`.
- IDLE→SEARCH on `start`:
  - `acc`=0, `i`=WIDTH-1.
  - Clear `found`, `cmp_err` and `value` (`value`←0).
- In SEARCH, combinationally `trial` = `acc` | (1<<`i`). The comparator is combinational, so results are sampled at the same edge.
- Per-step decision at each edge:
  - `a_g_b` or `a_e_b`: keep bit `i` (`acc`←`trial`).
  - `a_l_b`: clear bit `i`.
  - `a_e_b` also sets `found`.
- Non-one-hot triple (none, or more than one, asserted): set `cmp_err` and treat the step as `a_l_b` (clear).
- Termination: after step `i`=0, or on equality when early exit is enabled.
  - `value`←final `acc`.
  - `done`=1 for one cycle.
  - Return to IDLE.
- `start` while `busy` is ignored.
- `start` in the cycle where `done`=1 is accepted, because state is already IDLE.
- Target 0 never produces equality: the result is `value`=0 with `found`=0. This is legal.

## Timing
- Reset value of every output is 0: `trial`, `busy`, `done`, `value`, `found`, `cmp_err`.
- Edge k samples `start`. From cycle k+1: `busy`=1 and `trial`=1<<(WIDTH-1).
- Step n (n=0..WIDTH-1) is sampled at edge k+1+n.
- Full search: `done`=1, `busy`=0 and `value` valid in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start.
- Early exit at step n: `done` follows edge k+1+n.
- `rst` mid-search: all outputs return to 0 in the following cycle, no `done` pulse, state IDLE.
- `rst` and `start` asserted together: reset wins.

## Configuration
- `SAR_EARLY_EXIT_EN` defined:
  - `a_e_b` terminates the search at that step.
  - `value`=`trial` for that step.
  - Remaining bits are 0, which is consistent with the keep/clear rule.
- `SAR_EARLY_EXIT_EN` undefined:
  - Always WIDTH comparisons.
  - `value` is identical for valid comparators; only latency differs.

## Structure
- Package `sar_pkg`:
  - state enum (IDLE, SEARCH).
  - default width constant `SAR_WIDTH`=4.
  - index width `$clog2(WIDTH)`.
- One sub-module, `cmp_onehot_chk`: combinational, takes the three comparator bits and returns valid/invalid. It is reused by future comparator users.

## Test plan
Bench instantiates `comparator4bit` with `a`=target, `b`=`trial`; WIDTH=4.
- Target 11, EN off → trials 8,12,10,11; `value`=11, `found`=1; `done` 5 cycles after start.
- Target 8 → EN on: trial 8 only, `done` 2 cycles after start. EN off: trials 8,12,10,9; `value`=8, `found`=1.
- Target 0 → trials 8,4,2,1; `value`=0, `found`=0. Target 15 → trials 8,12,14,15; `value`=15.
- Target 5 then `start` during the `done` cycle with target 6 → second search begins immediately; `value`=6. A `start` pulse mid-search is ignored.
- Assert `rst` at step 2 of target 13 → next cycle all outputs 0, no `done`. A restart with target 13 gives `value`=13.
- Force `a_g_b`=`a_e_b`=`a_l_b`=0 for the step with `trial`=8 (bench drives these three inputs directly, not the comparator, for that step), target 3 → `cmp_err`=1 held; `value`=3. Next `start` clears `cmp_err`.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: shared types and sizing for the successive-approximation search engine.
package sar_pkg;
  typedef enum logic {IDLE, SEARCH} state_t;
  localparam int SAR_WIDTH = 4;
  function automatic int sar_idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/cmp_onehot_chk.sv
// cmp_onehot_chk: flags whether a greater/equal/less comparator triple is exactly one-hot.
module cmp_onehot_chk (
  input  logic i_a_g_b,
  input  logic i_a_e_b,
  input  logic i_a_l_b,
  output logic o_valid
);
  assign o_valid = (i_a_g_b & ~i_a_e_b & ~i_a_l_b) |
                   (~i_a_g_b & i_a_e_b & ~i_a_l_b) |
                   (~i_a_g_b & ~i_a_e_b & i_a_l_b);
endmodule

// File: rtl/sar_search.sv
// sar_search: MSB-first binary search of a comparator target, one step per clock.
// Define SAR_EARLY_EXIT_EN to terminate the search on the first equality.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_a_g_b,
  input  logic             i_a_e_b,
  input  logic             i_a_l_b,
  output logic [WIDTH-1:0] o_trial,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_value,
  output logic             o_found,
  output logic             o_cmp_err
);
  localparam int IW = sar_idx_w(WIDTH);
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_value;
  logic             r_done;
  logic             r_found;
  logic             r_err;
  logic             w_valid;
  logic             w_eq;
  logic             w_last;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_next_acc;
  cmp_onehot_chk u_chk (
    .i_a_g_b (i_a_g_b),
    .i_a_e_b (i_a_e_b),
    .i_a_l_b (i_a_l_b),
    .o_valid (w_valid)
  );
  assign w_trial    = (r_state == SEARCH) ? (r_acc | (WIDTH'(1) << r_idx)) : '0;
  // an invalid triple is treated as "less", so the trial bit is dropped
  assign w_eq       = w_valid & i_a_e_b;
  assign w_next_acc = (w_valid & (i_a_g_b | i_a_e_b)) ? w_trial : r_acc;
  assign w_last     = (r_idx == '0) | (EARLY & w_eq);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_value <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_state <= SEARCH;
          r_idx   <= TOP_IDX;
          r_acc   <= '0;
          r_value <= '0;
          r_found <= 1'b0;
          r_err   <= 1'b0;
        end
      end else begin
        r_acc   <= w_next_acc;
        r_found <= r_found | w_eq;
        r_err   <= r_err | ~w_valid;
        if (w_last) begin
          r_state <= IDLE;
          r_value <= w_next_acc;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end
  assign o_trial   = w_trial;
  assign o_busy    = (r_state == SEARCH);
  assign o_done    = r_done;
  assign o_value   = r_value;
  assign o_found   = r_found;
  assign o_cmp_err = r_err;
endmodule
